// File: rtl/lcd_panel_writer.sv
// Ping-pong capture of 9-pixel window bursts, replayed to the LCD panel bus
// with a timed setup/strobe/hold cycle per pixel.
module lcd_panel_writer #(
  parameter int WE_WIDTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       ready,
  output logic [7:0] lcd_data,
  output logic [3:0] lcd_addr,
  output logic       lcd_rs,
  output logic       lcd_we,
  output logic       frame_done,
  output logic       overflow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] STROBE_LAST = 3'(WE_WIDTH - 1);

  logic [7:0] mem_r [0:1][0:8];
  logic [1:0] full_r;
  logic       wbank_r;
  logic [3:0] widx_r;
  logic       rbank_r;
  logic [3:0] ridx_r;
  logic [2:0] cnt_r;
  state_t     state_r;

  logic [7:0] lcd_data_r;
  logic [3:0] lcd_addr_r;
  logic       lcd_rs_r;
  logic       lcd_we_r;
  logic       frame_done_r;
  logic       overflow_r;

  logic       release_s;
  logic       ready_s;
  logic       accept_s;
  logic [3:0] ridx_nxt_s;

  // Panel row boundaries fall on pixels 0, 3 and 6 of the 3x3 window.
  function automatic logic row_start(input logic [3:0] idx);
    row_start = (idx == 4'd0) || (idx == 4'd3) || (idx == 4'd6);
  endfunction

  // Bank release during DONE is visible to the writer in the same cycle.
  always_comb begin
    release_s  = (state_r == S_DONE);
    ready_s    = !full_r[wbank_r] || (release_s && (rbank_r == wbank_r));
    accept_s   = pix_valid && ready_s;
    ridx_nxt_s = ridx_r + 4'd1;
  end

  assign ready      = ready_s;
  assign lcd_data   = lcd_data_r;
  assign lcd_addr   = lcd_addr_r;
  assign lcd_rs     = lcd_rs_r;
  assign lcd_we     = lcd_we_r;
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;

  // Write side: capture pixels into the write bank, track bank-full flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 9; i++) begin
          mem_r[b][i] <= 8'd0;
        end
      end
      full_r     <= 2'b00;
      wbank_r    <= 1'b0;
      widx_r     <= 4'd0;
      overflow_r <= 1'b0;
    end else begin
      if (release_s) begin
        full_r[rbank_r] <= 1'b0;
      end
      if (pix_valid) begin
        if (accept_s) begin
          mem_r[wbank_r][widx_r] <= pix_in;
          if (widx_r == 4'd8) begin
            full_r[wbank_r] <= 1'b1;
            widx_r          <= 4'd0;
            wbank_r         <= ~wbank_r;
          end else begin
            widx_r <= widx_r + 4'd1;
          end
        end else begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  // Reader FSM: outputs are loaded on entry to each state so they track it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      rbank_r      <= 1'b0;
      ridx_r       <= 4'd0;
      cnt_r        <= 3'd0;
      lcd_data_r   <= 8'd0;
      lcd_addr_r   <= 4'd0;
      lcd_rs_r     <= 1'b0;
      lcd_we_r     <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          lcd_we_r     <= 1'b0;
          lcd_rs_r     <= 1'b0;
          frame_done_r <= 1'b0;
          if (full_r[rbank_r]) begin
            state_r    <= S_SETUP;
            lcd_data_r <= mem_r[rbank_r][ridx_r];
            lcd_addr_r <= ridx_r;
            lcd_rs_r   <= row_start(ridx_r);
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_SETUP: begin
          state_r  <= S_STROBE;
          lcd_we_r <= 1'b1;
          cnt_r    <= STROBE_LAST;
        end
        S_STROBE: begin
          if (cnt_r == 3'd0) begin
            state_r  <= S_HOLD;
            lcd_we_r <= 1'b0;
            lcd_rs_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        S_HOLD: begin
          if (ridx_r < 4'd8) begin
            state_r    <= S_SETUP;
            ridx_r     <= ridx_nxt_s;
            lcd_data_r <= mem_r[rbank_r][ridx_nxt_s];
            lcd_addr_r <= ridx_nxt_s;
            lcd_rs_r   <= row_start(ridx_nxt_s);
          end else begin
            state_r      <= S_DONE;
            frame_done_r <= 1'b1;
          end
        end
        S_DONE: begin
          frame_done_r <= 1'b0;
          rbank_r      <= ~rbank_r;
          ridx_r       <= 4'd0;
          // Chain straight into the other bank when it is already waiting.
          if (full_r[~rbank_r]) begin
            state_r    <= S_SETUP;
            lcd_data_r <= mem_r[~rbank_r][0];
            lcd_addr_r <= 4'd0;
            lcd_rs_r   <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          lcd_we_r     <= 1'b0;
          lcd_rs_r     <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
